// File: rtl/rs5_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Resolves BITS_PER_CYCLE quotient bits per cycle and supports abort via kill_i.
package RS5_pkg;
    typedef enum logic [1:0] {
        D_IDLE,
        D_INIT,
        D_CALC,
        D_SIGN
    } div_states_e;
endpackage

module rs5_divider
    import RS5_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_states_e state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] div_mag_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quot_q;
    logic             neg_rem_q;

    logic             signed_op;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] result_raw;

    function automatic logic [WIDTH-1:0] cond_negate(input logic signed [WIDTH-1:0] v,
                                                     input logic en);
        return en ? -v : v;
    endfunction

    // One D_CALC cycle: BITS_PER_CYCLE restoring steps; returns {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] rem,
                                                     input logic [WIDTH-1:0] quot,
                                                     input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] rr;
        logic [WIDTH-1:0] q;
        rr = rem;
        q  = quot;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r = {rr, q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, dvs}) begin
                r    = r - {1'b0, dvs};
                q[0] = 1'b1;
            end
            rr = r[WIDTH-1:0];
        end
        return {rr, q};
    endfunction

    assign signed_op = ~op_q[0];
    assign div_zero  = (divisor_q == '0);
    assign overflow  = signed_op && (dividend_q == MIN_INT) && (divisor_q == '1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            D_IDLE: if (start_i && !kill_i) state_d = D_INIT;
            D_INIT: state_d = (div_zero || overflow) ? D_SIGN : D_CALC;
            D_CALC: if (cnt_q == CNT_ONE) state_d = D_SIGN;
            D_SIGN: state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
        if (kill_i) state_d = D_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            div_mag_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            unique case (state_q)
                D_IDLE: begin
                    if (start_i && !kill_i) begin
                        op_q       <= op_i;
                        dividend_q <= dividend_i;
                        divisor_q  <= divisor_i;
                    end
                end
                D_INIT: begin
                    cnt_q <= N_CNT;
                    // Special cases load their final values so D_SIGN passes them through.
                    if (div_zero) begin
                        quot_q     <= '1;
                        rem_q      <= dividend_q;
                        neg_quot_q <= 1'b0;
                        neg_rem_q  <= 1'b0;
                    end else if (overflow) begin
                        quot_q     <= MIN_INT;
                        rem_q      <= '0;
                        neg_quot_q <= 1'b0;
                        neg_rem_q  <= 1'b0;
                    end else begin
                        quot_q     <= cond_negate(dividend_q, signed_op && dividend_q[WIDTH-1]);
                        div_mag_q  <= cond_negate(divisor_q, signed_op && divisor_q[WIDTH-1]);
                        rem_q      <= '0;
                        neg_quot_q <= signed_op && (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                        neg_rem_q  <= signed_op && dividend_q[WIDTH-1];
                    end
                end
                D_CALC: begin
                    {rem_q, quot_q} <= div_steps(rem_q, quot_q, div_mag_q);
                    cnt_q           <= cnt_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign result_raw = op_q[1] ? cond_negate(rem_q, neg_rem_q)
                                : cond_negate(quot_q, neg_quot_q);

    assign busy_o   = (state_q != D_IDLE);
    assign valid_o  = (state_q == D_SIGN) && !kill_i && !reset;
    assign result_o = valid_o ? result_raw : '0;

endmodule

// File: tb/tb_rs5_divider.sv
// Scoreboard bench for rs5_divider: three configurations, random and directed ops
// against an arithmetic reference model, plus kill/reset abort scenarios.
module tb_rs5_divider;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    int w_of[3] = '{32, 32, 16};
    int n_of[3] = '{32, 8, 8};

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s[3];
    logic        kill_s[3];
    logic        busy_s[3];
    logic        valid_s[3];
    logic [1:0]  op_s[3];
    logic [31:0] a_s[3];
    logic [31:0] b_s[3];
    logic [31:0] res0, res1;
    logic [15:0] res2;

    exp_t scb[3][$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs5_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_div0 (
        .clk(clk), .reset(reset), .start_i(start_s[0]), .kill_i(kill_s[0]), .op_i(op_s[0]),
        .dividend_i(a_s[0]), .divisor_i(b_s[0]), .busy_o(busy_s[0]), .valid_o(valid_s[0]),
        .result_o(res0));
    rs5_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_div1 (
        .clk(clk), .reset(reset), .start_i(start_s[1]), .kill_i(kill_s[1]), .op_i(op_s[1]),
        .dividend_i(a_s[1]), .divisor_i(b_s[1]), .busy_o(busy_s[1]), .valid_o(valid_s[1]),
        .result_o(res1));
    rs5_divider #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_div2 (
        .clk(clk), .reset(reset), .start_i(start_s[2]), .kill_i(kill_s[2]), .op_i(op_s[2]),
        .dividend_i(a_s[2][15:0]), .divisor_i(b_s[2][15:0]), .busy_o(busy_s[2]),
        .valid_o(valid_s[2]), .result_o(res2));

    // Reference: RISC-V M-extension semantics using 64-bit integer arithmetic.
    task automatic model(input int w, input logic [1:0] op, input logic [31:0] a, b,
                         output logic [31:0] res, output bit special);
        longint mask, ua, ub, sa, sbv, q, r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sbv  = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        special = (ub == 0) || (!op[0] && sa == -(longint'(1) << (w - 1)) && sbv == -1);
        if (ub == 0) begin
            q = mask;
            r = ua;
        end else if (!op[0]) begin
            q = sa / sbv;
            r = sa % sbv;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        res = 32'((op[1] ? r : q) & mask);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] r);
        exp_t e;
        checks++;
        if (v === 1'b1) begin
            if (scb[k].size() == 0) begin
                $display("FAIL unexpected_valid dut%0d: got valid result 0x%08h at cycle %0d, required none",
                         k, r, cyc);
            end else begin
                e = scb[k].pop_front();
                if (r === e.res && cyc == e.cyc) passed++;
                else $display("FAIL result dut%0d: got 0x%08h at cycle %0d, required 0x%08h at cycle %0d",
                              k, r, cyc, e.res, e.cyc);
            end
        end else begin
            if (v === 1'b0 && r === 32'h0) passed++;
            else $display("FAIL idle_output dut%0d: got valid=%b result=0x%08h, required 0/0",
                          k, v, r);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, valid_s[0], res0);
            mon(1, valid_s[1], res1);
            mon(2, valid_s[2], {16'h0, res2});
        end
    end

    // Called at a negedge; returns at the following negedge with start released.
    task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a, b,
                         input bit track, output int t);
        int   guard;
        exp_t e;
        bit   special;
        guard = 0;
        while (busy_s[k] !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            $display("FAIL issue_wait dut%0d: got busy for 100 cycles, required idle", k);
        end
        start_s[k] = 1'b1;
        op_s[k]    = op;
        a_s[k]     = a;
        b_s[k]     = b;
        t          = cyc;
        if (track) begin
            model(w_of[k], op, a, b, e.res, special);
            e.cyc = t + (special ? 2 : n_of[k] + 2);
            scb[k].push_back(e);
        end
        @(negedge clk);
        start_s[k] = 1'b0;
        op_s[k]    = 2'($urandom);
        a_s[k]     = $urandom;
        b_s[k]     = $urandom;
    endtask

    task automatic gen(input int w, output logic [31:0] a, b);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 5))
            0: begin a = $urandom; b = 32'h0; end
            1: begin a = 32'h1 << (w - 1); b = m; end
            2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 12); end
            3: begin a = $urandom; b = $urandom & 32'h0000_000F; end
            default: begin a = $urandom; b = $urandom; end
        endcase
        a = a & m;
        b = b & m;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [31:0] a, b;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            kill_s[k]  = 1'b0;
            op_s[k]    = 2'b00;
            a_s[k]     = 32'h0;
            b_s[k]     = 32'h0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'h0, busy_s[0]}, 32'h0);
        chk("reset_valid", {31'h0, valid_s[0]}, 32'h0);
        chk("reset_result", res0, 32'h0);
        mon_en = 1'b1;

        // Directed operations on the 32-bit, one-bit-per-cycle instance.
        issue(0, 2'b01, 32'd100, 32'd7, 1'b1, t);
        issue(0, 2'b11, 32'd100, 32'd7, 1'b1, t);
        issue(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, t);
        issue(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, t);
        issue(0, 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, t);
        issue(0, 2'b00, 32'd5, 32'd0, 1'b1, t);
        issue(0, 2'b11, 32'd5, 32'd0, 1'b1, t);
        issue(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t);
        issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t);

        // Kill mid-calculation, then an immediate restart.
        issue(0, 2'b01, 32'd1000, 32'd3, 1'b0, t);
        while (cyc < t + 10) @(negedge clk);
        kill_s[0] = 1'b1;
        @(negedge clk);
        kill_s[0] = 1'b0;
        chk("kill_busy", {31'h0, busy_s[0]}, 32'h0);
        issue(0, 2'b01, 32'd12345, 32'd11, 1'b1, t);

        // Kill while the result is being presented.
        issue(0, 2'b00, 32'd9, 32'd0, 1'b0, t);
        while (cyc < t + 2) @(negedge clk);
        kill_s[0] = 1'b1;
        @(negedge clk);
        kill_s[0] = 1'b0;
        chk("kill_sign_busy", {31'h0, busy_s[0]}, 32'h0);

        // Kill and start together in idle: start must be refused.
        while (busy_s[0] !== 1'b0) @(negedge clk);
        start_s[0] = 1'b1;
        kill_s[0]  = 1'b1;
        a_s[0]     = 32'd50;
        b_s[0]     = 32'd5;
        @(negedge clk);
        start_s[0] = 1'b0;
        kill_s[0]  = 1'b0;
        chk("kill_start_busy", {31'h0, busy_s[0]}, 32'h0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a signed divide.
        issue(0, 2'b00, 32'hFFFF_0000, 32'd17, 1'b0, t);
        while (cyc < t + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_busy", {31'h0, busy_s[0]}, 32'h0);
        chk("reset_mid_result", res0, 32'h0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            gen(32, a, b);
            issue(0, 2'($urandom), a, b, 1'b1, t);
        end

        issue(1, 2'b01, 32'hFFFF_FFFF, 32'd3, 1'b1, t);
        for (int i = 0; i < 20; i++) begin
            gen(32, a, b);
            issue(1, 2'($urandom), a, b, 1'b1, t);
        end

        issue(2, 2'b11, 32'h0000_FFFF, 32'h0000_0100, 1'b1, t);
        for (int i = 0; i < 20; i++) begin
            gen(16, a, b);
            issue(2, 2'($urandom), a, b, 1'b1, t);
        end

        for (int i = 0; i < 100; i++) begin
            if (scb[0].size() == 0 && scb[1].size() == 0 && scb[2].size() == 0) break;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            if (scb[k].size() != 0) begin
                checks++;
                $display("FAIL drain dut%0d: got %0d results outstanding, required 0", k, scb[k].size());
            end
        end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
